lsh_bucket_table: RTL
=====================

Name: lsh_bucket_table

Overview:
- Sequential, handshaked successor to the single-cycle LSH hash table.
- Stores window IDs in NUM_BUCKETS buckets of BUCKET_SIZE entries, indexed by the hashed sketch.
- Insert: writes one bucket per cycle. Query: accumulates per-window hit counts, then read-and-clear scans them and returns the best-matching window ID and its count.
- Adds overflow accounting, in-insert bucket dedup, a clear command and a result handshake.

Parameters:
- SKETCH_SIZE, 16, hashed k-mer values per sketch.
- NUM_BUCKETS, 256, number of buckets.
- LOG2_NUM_BUCKETS, 8, bucket index width.
- BUCKET_SIZE, 16, entries per bucket.
- NUM_WINDOWS, 1024, number of distinct window IDs.
- ID_WIDTH, 10, window ID width; must equal log2(NUM_WINDOWS).
- CNT_WIDTH, 5, per-window hit counter width; saturating.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 insert, 01 query, 10 clear, 11 no-op (accepted, ignored).
- cmd_id  in  ID_WIDTH  window ID for insert.
- cmd_sketch  in  SKETCH_SIZE*LOG2_NUM_BUCKETS  flat sketch; element i is at bits [i*LOG2_NUM_BUCKETS +: LOG2_NUM_BUCKETS].
- res_valid  out  1  query result valid.
- res_ready  in  1  result accepted.
- res_id  out  ID_WIDTH  best window ID.
- res_count  out  CNT_WIDTH  best window's hit count.
- res_hit  out  1  res_count != 0.
- busy  out  1  not IDLE.
- overflow  out  1  sticky: at least one insert was dropped.
- drop_count  out  16  saturating count of dropped inserts.

Behaviour:
- Reset values:
  - state IDLE; all bucket lengths 0; all counts 0; visited bitmap 0.
  - res_valid 0, res_id 0, res_count 0, res_hit 0, overflow 0, drop_count 0, busy 0, cmd_ready 1.
  - Entry storage need not be reset; lengths gate all reads.
- Handshake:
  - Command accepted on a rising edge with cmd_valid & cmd_ready.
  - Sketch and ID are latched at acceptance; later input changes have no effect.
  - On acceptance the visited bitmap is cleared.
- FSM: IDLE -> INS | QRY | IDLE (clear/no-op); INS -> IDLE; QRY -> SCAN -> RESP -> IDLE.
- INS:
  - Exactly SKETCH_SIZE cycles, element i in cycle i.
  - If bucket b is already visited in this insert: skip.
  - Else if len[b] == BUCKET_SIZE: drop, set overflow, drop_count +1 (saturates at 0xFFFF).
  - Else entry[b][len[b]] <= id, len[b] +1.
  - Mark b visited in all cases.
  - Returns to IDLE after the cycle that handles element SKETCH_SIZE-1.
- QRY:
  - Visited element: 1 cycle, no count change.
  - Unvisited element: max(1, len[b]) cycles; each cycle reads one entry j < len[b] and increments count[entry], saturating at 2^CNT_WIDTH-1. Bucket then marked visited.
  - Each bucket is therefore counted at most once per query.
- SCAN:
  - NUM_WINDOWS cycles, window w in cycle w.
  - Track the maximum count; update only on strictly greater, so ties resolve to the lowest ID.
  - count[w] <= 0 as it is read, so counts are zero at every query start.
- RESP:
  - res_valid = 1; res_id, res_count, res_hit stable until res_valid & res_ready, then IDLE.
  - All counts zero -> res_id 0, res_count 0, res_hit 0.
- Clear: in the acceptance cycle all len <= 0 and overflow <= 0; drop_count is retained; back in IDLE next cycle.
- Query latency: acceptance at edge T, QRY from T+1, SCAN follows, res_valid high on the cycle after the last SCAN cycle.
  - 16 distinct buckets of length 1: res_valid at T+1+16+1024.
- Insert with an empty bucket sets len to 1; inserting into a full bucket never corrupts other buckets.
- Reset asserted mid-operation: immediate return to reset values; the table is emptied, and any in-flight query result is discarded.
- res_ready is ignored outside RESP.

Test Plan:
- Insert id 5, sketch = buckets 0..15; then query the same sketch -> busy for 16 cycles on insert; res_valid at T+1041; res_id 5, res_count 16, res_hit 1.
- Insert id 7, sketch all 16 elements = bucket 3 -> len[3] = 1; query the same sketch -> res_count 1 (dedup on both paths).
- Insert ids 0..16, each sketch with all elements = bucket 9 -> overflow 1, drop_count 1; query bucket 9 -> res_id 0, res_count 1.
- Ids 4 and 2 inserted with identical sketches; query -> res_id 2 (tie resolves to lowest ID), res_count 16; an immediately repeated query gives the identical result (counts were cleared by the scan).
- Clear after inserts, then query -> res_hit 0, res_id 0; drop_count unchanged.
- Hold res_ready low for 20 cycles in RESP -> res_* stable, cmd_ready 0; assert reset mid-SCAN -> IDLE, res_valid 0, later query -> res_hit 0.

Source files
------------

// File: rtl/lsh_bucket_table_if.sv
`default_nettype none
// ============================================================================
// Module      : lsh_bucket_table_if
// Description : Command / result bundle for the LSH bucket table.
//               master : issues commands, accepts results (testbench / host)
//               slave  : the table itself
//   cmd_valid/cmd_ready/cmd_op/cmd_id/cmd_sketch : command handshake
//   res_valid/res_ready/res_id/res_count/res_hit : query result handshake
//   busy/overflow/drop_count                     : status
// Revision    : 1.0 - initial release
// ============================================================================
interface lsh_bucket_table_if #(
  parameter int SKETCH_SIZE      = 16,
  parameter int LOG2_NUM_BUCKETS = 8,
  parameter int ID_WIDTH         = 10,
  parameter int CNT_WIDTH        = 5
);
  logic                                      cmd_valid;
  logic                                      cmd_ready;
  logic [1:0]                                cmd_op;
  logic [ID_WIDTH-1:0]                       cmd_id;
  logic [SKETCH_SIZE*LOG2_NUM_BUCKETS-1:0]   cmd_sketch;
  logic                                      res_valid;
  logic                                      res_ready;
  logic [ID_WIDTH-1:0]                       res_id;
  logic [CNT_WIDTH-1:0]                      res_count;
  logic                                      res_hit;
  logic                                      busy;
  logic                                      overflow;
  logic [15:0]                               drop_count;

  modport master (
    output cmd_valid, cmd_op, cmd_id, cmd_sketch, res_ready,
    input  cmd_ready, res_valid, res_id, res_count, res_hit,
           busy, overflow, drop_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_id, cmd_sketch, res_ready,
    output cmd_ready, res_valid, res_id, res_count, res_hit,
           busy, overflow, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/lsh_bucket_table.sv
`default_nettype none
// ============================================================================
// Module      : lsh_bucket_table
// Description : Sequential LSH bucket table. Insert appends a window ID to
//               each (distinct) bucket of a sketch, one element per cycle.
//               Query accumulates per-window hit counts over the sketch's
//               buckets, then a read-and-clear scan returns the best window.
// Ports       : clk, reset (async, active-high)
//               bus (lsh_bucket_table_if.slave): command / result / status
// Revision    : 1.0 - initial release
// ============================================================================
module lsh_bucket_table #(
  parameter int SKETCH_SIZE      = 16,
  parameter int NUM_BUCKETS      = 256,
  parameter int LOG2_NUM_BUCKETS = 8,
  parameter int BUCKET_SIZE      = 16,
  parameter int NUM_WINDOWS      = 1024,
  parameter int ID_WIDTH         = 10,
  parameter int CNT_WIDTH        = 5
) (
  input  wire logic          clk,
  input  wire logic          reset,
  lsh_bucket_table_if.slave  bus
);

  localparam int LEN_W  = $clog2(BUCKET_SIZE + 1);
  localparam int J_W    = $clog2(BUCKET_SIZE);
  localparam int ELEM_W = $clog2(SKETCH_SIZE);
  localparam int SK_W   = SKETCH_SIZE * LOG2_NUM_BUCKETS;
  localparam logic [LEN_W-1:0]     FULL_LEN  = LEN_W'(BUCKET_SIZE);
  localparam logic [ELEM_W-1:0]    LAST_ELEM = ELEM_W'(SKETCH_SIZE - 1);
  localparam logic [ID_WIDTH-1:0]  LAST_WIN  = ID_WIDTH'(NUM_WINDOWS - 1);

  typedef enum logic [2:0] {IDLE, INS, QRY, SCAN, RESP} state_t;

  state_t                       r_state, w_next_state;
  logic [SK_W-1:0]              r_sketch;
  logic [ID_WIDTH-1:0]          r_id;
  logic [ELEM_W-1:0]            r_elem;
  logic [J_W-1:0]               r_j;
  logic [ID_WIDTH-1:0]          r_win;
  logic [ID_WIDTH-1:0]          r_best_id;
  logic [CNT_WIDTH-1:0]         r_best_cnt;
  logic                         r_overflow;
  logic [15:0]                  r_drop_count;
  logic [NUM_BUCKETS-1:0]       r_visited;
  logic [LEN_W-1:0]             r_len   [NUM_BUCKETS];
  logic [CNT_WIDTH-1:0]         r_count [NUM_WINDOWS];
  logic [ID_WIDTH-1:0]          r_entry [NUM_BUCKETS][BUCKET_SIZE];

  logic                         w_cmd_ready;
  logic                         w_busy;
  logic                         w_accept;
  logic [LOG2_NUM_BUCKETS-1:0]  w_bucket;
  logic [LEN_W-1:0]             w_len;
  logic                         w_seen;
  logic                         w_full;
  logic [ID_WIDTH-1:0]          w_entry_id;
  logic                         w_last_elem;
  logic                         w_last_j;
  logic                         w_qry_step;
  logic                         w_last_win;
  logic [CNT_WIDTH-1:0]         w_scan_cnt;

  assign w_accept    = bus.cmd_valid & w_cmd_ready;
  assign w_bucket    = r_sketch[int'(r_elem)*LOG2_NUM_BUCKETS +: LOG2_NUM_BUCKETS];
  assign w_len       = r_len[w_bucket];
  assign w_seen      = r_visited[w_bucket];
  assign w_full      = (w_len == FULL_LEN);
  assign w_entry_id  = r_entry[w_bucket][r_j];
  assign w_last_elem = (r_elem == LAST_ELEM);
  assign w_last_j    = ((LEN_W'(r_j) + LEN_W'(1)) == w_len);
  // A query moves on to the next element when the bucket needs no (more) reads.
  assign w_qry_step  = w_seen | (w_len == '0) | w_last_j;
  assign w_last_win  = (r_win == LAST_WIN);
  assign w_scan_cnt  = r_count[r_win];

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.busy       = w_busy;
  assign bus.res_valid  = (r_state == RESP);
  assign bus.res_id     = r_best_id;
  assign bus.res_count  = r_best_cnt;
  assign bus.res_hit    = (r_best_cnt != '0);
  assign bus.overflow   = r_overflow;
  assign bus.drop_count = r_drop_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_cmd_ready  = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        w_busy      = 1'b0;
        if (w_accept) begin
          if (bus.cmd_op == 2'b00)      w_next_state = INS;
          else if (bus.cmd_op == 2'b01) w_next_state = QRY;
        end
      end
      INS:  if (w_last_elem)              w_next_state = IDLE;
      QRY:  if (w_qry_step && w_last_elem) w_next_state = SCAN;
      SCAN: if (w_last_win)               w_next_state = RESP;
      RESP: if (bus.res_ready)            w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sketch     <= '0;
      r_id         <= '0;
      r_elem       <= '0;
      r_j          <= '0;
      r_win        <= '0;
      r_best_id    <= '0;
      r_best_cnt   <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_visited    <= '0;
      for (int b = 0; b < NUM_BUCKETS; b++) r_len[b] <= '0;
      for (int w = 0; w < NUM_WINDOWS; w++) r_count[w] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sketch  <= bus.cmd_sketch;
            r_id      <= bus.cmd_id;
            r_elem    <= '0;
            r_j       <= '0;
            r_visited <= '0;
            if (bus.cmd_op == 2'b10) begin
              for (int b = 0; b < NUM_BUCKETS; b++) r_len[b] <= '0;
              r_overflow <= 1'b0;
            end
          end
        end
        INS: begin
          r_visited[w_bucket] <= 1'b1;
          if (!w_seen) begin
            if (w_full) begin
              r_overflow <= 1'b1;
              if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
            end else begin
              r_len[w_bucket] <= w_len + LEN_W'(1);
            end
          end
          r_elem <= r_elem + ELEM_W'(1);
        end
        QRY: begin
          if (w_seen || (w_len == '0)) begin
            r_visited[w_bucket] <= 1'b1;
            r_elem              <= r_elem + ELEM_W'(1);
          end else begin
            if (r_count[w_entry_id] != '1)
              r_count[w_entry_id] <= r_count[w_entry_id] + CNT_WIDTH'(1);
            if (w_last_j) begin
              r_visited[w_bucket] <= 1'b1;
              r_j                 <= '0;
              r_elem              <= r_elem + ELEM_W'(1);
            end else begin
              r_j <= r_j + J_W'(1);
            end
          end
          if (w_qry_step && w_last_elem) begin
            r_win      <= '0;
            r_best_id  <= '0;
            r_best_cnt <= '0;
          end
        end
        SCAN: begin
          // Strictly-greater update keeps the lowest ID on ties.
          if (w_scan_cnt > r_best_cnt) begin
            r_best_id  <= r_win;
            r_best_cnt <= w_scan_cnt;
          end
          r_count[r_win] <= '0;
          r_win          <= r_win + ID_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Entry storage carries no reset; bucket lengths gate every read.
  always_ff @(posedge clk) begin
    if ((r_state == INS) && !w_seen && !w_full)
      r_entry[w_bucket][w_len[J_W-1:0]] <= r_id;
  end

endmodule
`default_nettype wire
